// File: rtl/nixie_scan_ctrl.sv
// Time-multiplexed digit scanner with a frame-aligned pending/shadow buffer,
// blanking gaps between digits and leading-zero suppression.
module nixie_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 5000,
  parameter int BLANK  = 8
) (
  input  logic                Sys_CLK,
  input  logic                Sys_RST_N,
  input  logic                EN,
  input  logic [4*DIGITS-1:0] Data_BCD,
  input  logic [DIGITS-1:0]   DP_Mask,
  input  logic                LZ_Suppress,
  input  logic                Data_Valid,
  output logic                Data_Ready,
  output logic [DIGITS-1:0]   COM,
  output logic [7:0]          SEG,
  output logic                Frame_Done
);

  localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [CW-1:0]     SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0]     LAST_DIGIT = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0   = DIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW, S_BLANK} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       next_idx;
  logic                pend_full;
  logic [4*DIGITS-1:0] pend_data;
  logic [4*DIGITS-1:0] shad_data;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   shad_dp;

  assign Data_Ready = ~pend_full;
  assign next_idx   = idx + 1'b1;

  function automatic logic [6:0] seven(input logic [3:0] nib);
    case (nib)
      4'd0:    seven = 7'b1111110;
      4'd1:    seven = 7'b0110000;
      4'd2:    seven = 7'b1101101;
      4'd3:    seven = 7'b1111001;
      4'd4:    seven = 7'b0110011;
      4'd5:    seven = 7'b1011011;
      4'd6:    seven = 7'b1011111;
      4'd7:    seven = 7'b1110000;
      4'd8:    seven = 7'b1111111;
      4'd9:    seven = 7'b1111011;
      default: seven = 7'b0000000;
    endcase
  endfunction

  // A digit is blanked only if it and every more significant digit are zero;
  // the decimal point is kept even on a blanked digit.
  function automatic logic [7:0] encode(input logic [IW-1:0]       sel,
                                        input logic [4*DIGITS-1:0] data,
                                        input logic [DIGITS-1:0]   dp,
                                        input logic                lz);
    logic [3:0] nib;
    logic       upper_zero;
    nib        = data[4*int'(sel) +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j > int'(sel) && data[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (lz && sel != '0 && nib == 4'd0 && upper_zero) encode = {7'b0000000, dp[sel]};
    else                                              encode = {seven(nib), dp[sel]};
  endfunction

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      shad_data  <= '0;
      shad_dp    <= '0;
      COM        <= '0;
      SEG        <= '0;
      Frame_Done <= 1'b0;
    end else begin
      Frame_Done <= 1'b0;
      if (Data_Valid && !pend_full) begin
        pend_data <= Data_BCD;
        pend_dp   <= DP_Mask;
        pend_full <= 1'b1;
      end
      if (!EN) begin
        state <= S_IDLE;
        cnt   <= '0;
        idx   <= '0;
        COM   <= '0;
        SEG   <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_LOAD;
          // Digit 0 must be encoded from the word becoming visible this frame.
          S_LOAD: begin
            if (pend_full) begin
              shad_data <= pend_data;
              shad_dp   <= pend_dp;
              pend_full <= 1'b0;
              SEG       <= encode('0, pend_data, pend_dp, LZ_Suppress);
            end else begin
              SEG       <= encode('0, shad_data, shad_dp, LZ_Suppress);
            end
            idx   <= '0;
            cnt   <= '0;
            COM   <= ONE_HOT0;
            state <= S_SHOW;
          end
          S_SHOW: begin
            if (cnt == SHOW_LAST) begin
              cnt   <= '0;
              COM   <= '0;
              SEG   <= '0;
              state <= S_BLANK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_BLANK: begin
            if (cnt == BLANK_LAST) begin
              cnt <= '0;
              if (idx == LAST_DIGIT) begin
                Frame_Done <= 1'b1;
                state      <= S_LOAD;
              end else begin
                idx   <= next_idx;
                COM   <= ONE_HOT0 << next_idx;
                SEG   <= encode(next_idx, shad_data, shad_dp, LZ_Suppress);
                state <= S_SHOW;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Directed bench for nixie_scan_ctrl with DIGITS=4, DIV=4, BLANK=2 (25-cycle frame).
module tb_nixie_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 2;

  logic                Sys_CLK = 1'b0;
  logic                Sys_RST_N;
  logic                EN;
  logic [4*DIGITS-1:0] Data_BCD;
  logic [DIGITS-1:0]   DP_Mask;
  logic                LZ_Suppress;
  logic                Data_Valid;
  logic                Data_Ready;
  logic [DIGITS-1:0]   COM;
  logic [7:0]          SEG;
  logic                Frame_Done;

  int n_checks = 0;
  int n_fail   = 0;

  nixie_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .Sys_CLK     (Sys_CLK),
    .Sys_RST_N   (Sys_RST_N),
    .EN          (EN),
    .Data_BCD    (Data_BCD),
    .DP_Mask     (DP_Mask),
    .LZ_Suppress (LZ_Suppress),
    .Data_Valid  (Data_Valid),
    .Data_Ready  (Data_Ready),
    .COM         (COM),
    .SEG         (SEG),
    .Frame_Done  (Frame_Done)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  task automatic tick();
    @(posedge Sys_CLK);
    #1;
  endtask

  // Starts at the sample point of a LOAD cycle and ends at the next one.
  // exp_segs holds the expected SEG byte of digit k in bits [8k+7:8k].
  task automatic scan_frame(input logic [31:0] exp_segs, input string tag);
    logic [3:0] exp_com;
    logic [7:0] exp_seg;
    logic       exp_fd;
    for (int t = 1; t <= 25; t++) begin
      tick();
      exp_fd  = (t == 25);
      exp_com = '0;
      exp_seg = '0;
      if (t < 25 && ((t - 1) % 6) < 4) begin
        exp_com = 4'b0001 << ((t - 1) / 6);
        exp_seg = exp_segs[8*((t - 1) / 6) +: 8];
      end
      if (COM !== exp_com) begin
        $display("[TB] FAIL %s com t=%0d: got %b expected %b", tag, t, COM, exp_com);
        n_fail++;
      end
      n_checks++;
      if (SEG !== exp_seg) begin
        $display("[TB] FAIL %s seg t=%0d: got %b expected %b", tag, t, SEG, exp_seg);
        n_fail++;
      end
      n_checks++;
      if (Frame_Done !== exp_fd) begin
        $display("[TB] FAIL %s frame_done t=%0d: got %b expected %b", tag, t, Frame_Done, exp_fd);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_reset();
    Sys_RST_N   = 1'b0;
    EN          = 1'b1;
    Data_BCD    = '0;
    DP_Mask     = '0;
    LZ_Suppress = 1'b0;
    Data_Valid  = 1'b0;
    repeat (2) tick();
    if (COM !== 4'b0000) begin
      $display("[TB] FAIL reset com: got %b expected 0000", COM); n_fail++;
    end
    n_checks++;
    if (SEG !== 8'h00) begin
      $display("[TB] FAIL reset seg: got %b expected 00000000", SEG); n_fail++;
    end
    n_checks++;
    if (Frame_Done !== 1'b0) begin
      $display("[TB] FAIL reset frame_done: got %b expected 0", Frame_Done); n_fail++;
    end
    n_checks++;
    if (Data_Ready !== 1'b1) begin
      $display("[TB] FAIL reset data_ready: got %b expected 1", Data_Ready); n_fail++;
    end
    n_checks++;
    Sys_RST_N = 1'b1;
    tick();
    if (COM !== 4'b0000) begin
      $display("[TB] FAIL load com: got %b expected 0000", COM); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_blank_scan();
    scan_frame(32'hFCFCFCFC, "zero_frame1");
    scan_frame(32'hFCFCFCFC, "zero_frame2");
  endtask

  task automatic test_capture();
    fork
      scan_frame(32'hFCFCFCFC, "pre_capture");
      begin
        repeat (8) tick();
        if (Data_Ready !== 1'b1) begin
          $display("[TB] FAIL ready_before_capture: got %b expected 1", Data_Ready); n_fail++;
        end
        n_checks++;
        Data_BCD   = 16'h1234;
        DP_Mask    = 4'b0100;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        if (Data_Ready !== 1'b0) begin
          $display("[TB] FAIL ready_after_capture: got %b expected 0", Data_Ready); n_fail++;
        end
        n_checks++;
      end
    join
    if (Data_Ready !== 1'b0) begin
      $display("[TB] FAIL ready_at_load: got %b expected 0", Data_Ready); n_fail++;
    end
    n_checks++;
    fork
      scan_frame(32'h60DBF266, "word_1234");
      begin
        tick();
        if (Data_Ready !== 1'b1) begin
          $display("[TB] FAIL ready_after_load: got %b expected 1", Data_Ready); n_fail++;
        end
        n_checks++;
      end
    join
  endtask

  task automatic test_lz();
    Data_BCD    = 16'h0070;
    DP_Mask     = 4'b0000;
    LZ_Suppress = 1'b1;
    Data_Valid  = 1'b1;
    fork
      scan_frame(32'h60DBF266, "hold_1234");
      begin
        tick();
        Data_Valid = 1'b0;
        if (Data_Ready !== 1'b0) begin
          $display("[TB] FAIL lz_capture_ready: got %b expected 0", Data_Ready); n_fail++;
        end
        n_checks++;
      end
    join
    scan_frame(32'h0000E0FC, "lz_on_0070");
    LZ_Suppress = 1'b0;
    scan_frame(32'hFCFCE0FC, "lz_off_0070");
  endtask

  task automatic test_back_to_back();
    fork
      scan_frame(32'hFCFCE0FC, "b2b_old");
      begin
        repeat (3) tick();
        Data_BCD   = 16'h5678;
        DP_Mask    = 4'b0001;
        Data_Valid = 1'b1;
        tick();
        if (Data_Ready !== 1'b0) begin
          $display("[TB] FAIL b2b_word1_taken: got %b expected 0", Data_Ready); n_fail++;
        end
        n_checks++;
        Data_BCD = 16'h0905;
        DP_Mask  = 4'b1000;
      end
    join
    if (Data_Ready !== 1'b0) begin
      $display("[TB] FAIL b2b_word2_stalled: got %b expected 0", Data_Ready); n_fail++;
    end
    n_checks++;
    fork
      scan_frame(32'hB6BEE0FF, "b2b_word1");
      begin
        tick();
        if (Data_Ready !== 1'b1) begin
          $display("[TB] FAIL b2b_ready_after_load: got %b expected 1", Data_Ready); n_fail++;
        end
        n_checks++;
        tick();
        Data_Valid = 1'b0;
        if (Data_Ready !== 1'b0) begin
          $display("[TB] FAIL b2b_word2_taken: got %b expected 0", Data_Ready); n_fail++;
        end
        n_checks++;
      end
    join
    scan_frame(32'hFDF6FCB6, "b2b_word2");
  endtask

  task automatic test_enable_drop();
    repeat (14) tick();
    if (COM !== 4'b0100 || SEG !== 8'hF6) begin
      $display("[TB] FAIL en_pre_digit2: got com=%b seg=%b expected com=0100 seg=11110110", COM, SEG);
      n_fail++;
    end
    n_checks++;
    EN = 1'b0;
    tick();
    if (COM !== 4'b0000 || SEG !== 8'h00 || Frame_Done !== 1'b0) begin
      $display("[TB] FAIL en_drop: got com=%b seg=%b fd=%b expected all zero", COM, SEG, Frame_Done);
      n_fail++;
    end
    n_checks++;
    tick();
    if (COM !== 4'b0000 || SEG !== 8'h00) begin
      $display("[TB] FAIL en_idle: got com=%b seg=%b expected all zero", COM, SEG);
      n_fail++;
    end
    n_checks++;
    EN = 1'b1;
    tick();
    if (COM !== 4'b0000) begin
      $display("[TB] FAIL en_reload_com: got %b expected 0000", COM); n_fail++;
    end
    n_checks++;
    scan_frame(32'hFDF6FCB6, "en_restart");
  endtask

  task automatic test_bad_nibble_and_reset();
    Data_BCD   = 16'h00C3;
    DP_Mask    = 4'b0010;
    Data_Valid = 1'b1;
    fork
      scan_frame(32'hFDF6FCB6, "hold_0905");
      begin
        tick();
        Data_Valid = 1'b0;
      end
    join
    scan_frame(32'hFCFC01F2, "nibble_c");
    Data_BCD   = 16'h8888;
    DP_Mask    = 4'b1111;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    if (Data_Ready !== 1'b0) begin
      $display("[TB] FAIL rst_pending_ready: got %b expected 0", Data_Ready); n_fail++;
    end
    n_checks++;
    repeat (4) tick();
    if (COM !== 4'b0000) begin
      $display("[TB] FAIL rst_in_blank_com: got %b expected 0000", COM); n_fail++;
    end
    n_checks++;
    Sys_RST_N = 1'b0;
    #2;
    if (COM !== 4'b0000 || SEG !== 8'h00 || Frame_Done !== 1'b0) begin
      $display("[TB] FAIL rst_async_outputs: got com=%b seg=%b fd=%b expected all zero", COM, SEG, Frame_Done);
      n_fail++;
    end
    n_checks++;
    if (Data_Ready !== 1'b1) begin
      $display("[TB] FAIL rst_async_ready: got %b expected 1", Data_Ready); n_fail++;
    end
    n_checks++;
    tick();
    Sys_RST_N = 1'b1;
    tick();
    if (COM !== 4'b0000) begin
      $display("[TB] FAIL rst_reload_com: got %b expected 0000", COM); n_fail++;
    end
    n_checks++;
    // Shadow cleared and the pending 8888 lost: two frames of plain zeros.
    scan_frame(32'hFCFCFCFC, "post_rst1");
    scan_frame(32'hFCFCFCFC, "post_rst2");
    if (Data_Ready !== 1'b1) begin
      $display("[TB] FAIL post_rst_ready: got %b expected 1", Data_Ready); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_blank_scan();
    test_capture();
    test_lz();
    test_back_to_back();
    test_enable_drop();
    test_bad_nibble_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #60000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
